// File: rtl/toggle_hs_rx.sv
// -----------------------------------------------------------------------------
// toggle_hs_rx
//
// Receive end of a two-phase (toggle) handshake. Every transition of req_tog
// announces one word on data_in. The request is synchronised into the local
// clock domain. The word is captured into a single-entry buffer and offered on
// a valid/ready port. Each word the consumer accepts is answered with one
// transition of ack_tog. Delivered words are counted. A request that toggles
// again before it has been acknowledged raises a sticky error flag.
//
// Parameters
//   WIDTH        data word width
//   SYNC_STAGES  flops in the req_tog synchroniser (must be >= 2)
//   CNT_W        width of rx_count
//
// Ports
//   clock         rising-edge clock
//   clear         synchronous active-high reset; overrides every other event
//   req_tog       request toggle from the sender (asynchronous)
//   data_in       word from the sender; held stable until it sees ack_tog move
//   ack_tog       acknowledge toggle, one transition per delivered word
//   out_data      captured word
//   out_valid     out_data holds an undelivered word
//   out_ready     consumer accepts out_data this cycle
//   rx_count      number of delivered words, modulo 2^CNT_W
//   protocol_err  sticky flag: request toggled twice before acknowledge
// -----------------------------------------------------------------------------
module toggle_hs_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             req_tog,
    input  logic [WIDTH-1:0] data_in,
    output logic             ack_tog,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] rx_count,
    output logic             protocol_err
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // req_tog synchroniser. Stage 0 samples the asynchronous input; the last
    // stage (req_s) is the only one the control logic looks at.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   req_s;

    always_ff @(posedge clock) begin
        if (clear) begin
            sync_reg[0] <= 1'b0;
        end else begin
            sync_reg[0] <= req_tog;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clock) begin
                if (clear) begin
                    sync_reg[gi] <= 1'b0;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign req_s = sync_reg[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Receive FSM. A word is outstanding whenever the synchronised request
    // differs from our acknowledge. In HOLD the two normally differ. If they
    // are equal there, the sender has toggled a second time before it saw our
    // acknowledge. The buffered word is still delivered normally.
    // -------------------------------------------------------------------------
    state_t           state_reg;
    logic             ack_reg;
    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;
    logic [CNT_W-1:0] count_reg;
    logic             err_reg;

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg <= IDLE;
            ack_reg   <= 1'b0;
            valid_reg <= 1'b0;
            data_reg  <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // data_in is not synchronised. The sender keeps it stable
                    // from its toggle until it sees our ack. It is therefore
                    // settled by the time req_s shows the toggle.
                    if (req_s != ack_reg) begin
                        data_reg  <= data_in;
                        valid_reg <= 1'b1;
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (req_s == ack_reg) begin
                        err_reg <= 1'b1;
                    end
                    if (out_ready) begin
                        valid_reg <= 1'b0;
                        ack_reg   <= ~ack_reg;
                        count_reg <= count_reg + CNT_W'(1);
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ack_tog      = ack_reg;
    assign out_valid    = valid_reg;
    assign out_data     = data_reg;
    assign rx_count     = count_reg;
    assign protocol_err = err_reg;

endmodule

// File: tb/tb_toggle_hs_rx.sv
// -----------------------------------------------------------------------------
// tb_toggle_hs_rx
//
// Bench for toggle_hs_rx. Two instances share the same stimulus. One uses the
// default CNT_W. The other uses CNT_W = 2, so that the counter can be seen to
// wrap.
//
// The reference model works in terms of the handshake rules:
//   - The receiver sees the request SYNC_STAGES edges late. This is modelled
//     with a history ring of sampled req_tog values.
//   - ack equals the parity of the number of delivered words.
//   - rx_count equals the number of delivered words, modulo 2^CNT_W.
// A scoreboard of words sent by the bench checks data order independently.
// -----------------------------------------------------------------------------
module tb_toggle_hs_rx;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int CNT_W = 16;

    logic             clock = 1'b0;
    logic             clear = 1'b1;
    logic             req_tog = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             out_ready = 1'b0;

    logic             ack_tog, out_valid, protocol_err;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] rx_count;

    logic             ack_tog_w, out_valid_w, protocol_err_w;
    logic [WIDTH-1:0] out_data_w;
    logic [1:0]       rx_count_w;

    toggle_hs_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
        .clock(clock), .clear(clear), .req_tog(req_tog), .data_in(data_in),
        .ack_tog(ack_tog), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .rx_count(rx_count), .protocol_err(protocol_err)
    );

    toggle_hs_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .CNT_W(2)) dut_w (
        .clock(clock), .clear(clear), .req_tog(req_tog), .data_in(data_in),
        .ack_tog(ack_tog_w), .out_data(out_data_w), .out_valid(out_valid_w),
        .out_ready(out_ready), .rx_count(rx_count_w), .protocol_err(protocol_err_w)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    bit             req_ring [0:63];
    int             m_n       = 0;     // index of the current edge
    int             m_clr_edge = 0;    // edge at which clear was last sampled
    bit             model_ok  = 1'b0;
    bit             m_valid   = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    int             m_deliv   = 0;     // words delivered since clear
    bit             m_err     = 1'b0;

    // Returns the synchronised request as seen just before edge n. This is
    // the req_tog sampled SYNC edges earlier. Samples taken at or before a
    // clear count as 0.
    function automatic bit req_seen(input int n);
        if (n - SYNC > m_clr_edge) return req_ring[(n - SYNC) % 64];
        return 1'b0;
    endfunction

    always @(posedge clock) begin
        m_n <= m_n + 1;
        if (clear) begin
            model_ok   <= 1'b1;
            m_clr_edge <= m_n;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_deliv    <= 0;
            m_err      <= 1'b0;
            req_ring[m_n % 64] <= 1'b0;
        end else begin
            req_ring[m_n % 64] <= req_tog;
            if (!m_valid) begin
                if (req_seen(m_n) != m_deliv[0]) begin
                    m_valid <= 1'b1;
                    m_data  <= data_in;
                end
            end else begin
                if (req_seen(m_n) == m_deliv[0]) m_err <= 1'b1;
                if (out_ready) begin
                    m_valid <= 1'b0;
                    m_deliv <= m_deliv + 1;
                end
            end
        end
    end

    // Words the sender has announced but that have not yet been delivered.
    logic [WIDTH-1:0] sent_q[$];

    // ---------------------------------------------------------------- compare
    always @(negedge clock) begin
        if (model_ok) begin
            check("valid",     32'(out_valid),    32'(m_valid));
            check("data",      32'(out_data),     32'(m_data));
            check("ack",       32'(ack_tog),      32'(m_deliv[0]));
            check("count",     32'(rx_count),     32'(m_deliv[CNT_W-1:0]));
            check("err",       32'(protocol_err), 32'(m_err));
            check("valid_w",   32'(out_valid_w),  32'(m_valid));
            check("data_w",    32'(out_data_w),   32'(m_data));
            check("ack_w",     32'(ack_tog_w),    32'(m_deliv[0]));
            check("count_w",   32'(rx_count_w),   32'(m_deliv[1:0]));
            check("err_w",     32'(protocol_err_w), 32'(m_err));
            // A delivery happens at the next edge. Check it against the
            // word the sender announced.
            if (!clear && out_valid && out_ready) begin
                if (sent_q.size() == 0) begin
                    check("sb_extra_delivery", 32'(1), 32'(0));
                end else begin
                    check("sb_word", 32'(out_data), 32'(sent_q.pop_front()));
                end
            end
        end
    end

    // ---------------------------------------------------------------- sender
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] w);
        data_in = w;
        req_tog = ~req_tog;
        sent_q.push_back(w);
    endtask

    task automatic wait_ack(input bit rand_ready);
        logic a;
        bit   seen;
        a = ack_tog;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (ack_tog != a) seen = 1'b1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
        if (!seen) check("ack_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        if (!seen) check("valid_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_clear(input int n);
        clear     = 1'b1;
        req_tog   = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        sent_q.delete();
        repeat (n) tick();
        clear = 1'b0;
    endtask

    initial begin
        int lat;
        bit got;

        // Clear, then stay idle.
        tick();
        do_clear(3);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_outputs", {out_valid, ack_tog, protocol_err, out_data, rx_count}, 32'(0));
        end

        // Single word with out_ready tied high: valid appears 3 edges after the toggle.
        out_ready = 1'b1;
        send(8'hA5);
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 10 && !got; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                got = 1'b1;
            end
        end
        check("single_latency", 32'(lat), 32'(3));
        check("single_data", 32'(out_data), 32'(8'hA5));
        tick();
        check("single_valid_one_cycle", 32'(out_valid), 32'(0));
        check("single_ack", 32'(ack_tog), 32'(1));
        check("single_count", 32'(rx_count), 32'(1));

        // Back-pressure.
        out_ready = 1'b0;
        send(8'h3C);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_data", 32'(out_data), 32'(8'h3C));
            check("bp_ack", 32'(ack_tog), 32'(1));
        end
        out_ready = 1'b1;
        tick();
        check("bp_ack_toggle", 32'(ack_tog), 32'(0));
        check("bp_count", 32'(rx_count), 32'(2));

        // Stream of 4 words from a clean start.
        do_clear(1);
        out_ready = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            send(WIDTH'(w));
            wait_ack(1'b0);
        end
        repeat (2) tick();
        check("stream_ack", 32'(ack_tog), 32'(0));
        check("stream_count", 32'(rx_count), 32'(4));
        check("stream_err", 32'(protocol_err), 32'(0));

        // Violation: two toggles 2 cycles apart while the consumer stalls.
        out_ready = 1'b0;
        send(8'h77);
        tick();
        tick();
        send(8'h77);
        repeat (6) tick();
        check("viol_err", 32'(protocol_err), 32'(1));
        check("viol_held", 32'(out_valid), 32'(1));
        out_ready = 1'b1;
        tick();
        check("viol_first_delivered", 32'(rx_count), 32'(5));
        repeat (8) tick();
        check("viol_err_sticky", 32'(protocol_err), 32'(1));

        // Counter wrap with CNT_W = 2.
        do_clear(1);
        out_ready = 1'b1;
        for (int w = 0; w < 5; w++) begin
            send(8'h10 + WIDTH'(w));
            wait_ack(1'b0);
        end
        tick();
        check("wrap_count_w", 32'(rx_count_w), 32'(1));
        check("wrap_count", 32'(rx_count), 32'(5));

        // Clear while a word is pending: it is never acknowledged.
        out_ready = 1'b0;
        send(8'h5A);
        wait_valid();
        clear     = 1'b1;
        req_tog   = 1'b0;
        out_ready = 1'b1;
        sent_q.delete();
        tick();
        clear = 1'b0;
        check("midclr_outputs", {out_valid, ack_tog, protocol_err, out_data, rx_count}, 32'(0));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("midclr_no_ack", {out_valid, ack_tog, rx_count}, 32'(0));
        end

        // Randomised traffic: random words, gaps and consumer stalls.
        for (int k = 0; k < 200; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            send(WIDTH'($urandom));
            wait_ack(1'b1);
        end
        out_ready = 1'b1;
        repeat (5) tick();
        check("rand_err", 32'(protocol_err), 32'(0));
        check("rand_drained", 32'(sent_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
